// File: rtl/accel_pkg.sv
// accel_pkg -- shared definitions for the accelerometer moving-average block.
//   ACCEL_W     sample / average width (signed)
//   N_LOG2_DEF  default log2 of the averaging window
//   sum_w()     running-sum width for a given window size
//   state_t     control FSM state encoding
package accel_pkg;

  localparam int ACCEL_W    = 16;
  localparam int N_LOG2_DEF = 3;

  // 2**n_log2 full-scale samples need n_log2 extra bits to sum without overflow.
  function automatic int sum_w(input int n_log2);
    return ACCEL_W + n_log2;
  endfunction

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/accel_avg_channel.sv
// accel_avg_channel -- one axis of the moving-average filter: circular sample
// buffer, running sum and the shift (optionally rounded) down to an average.
// Optional feature macro: ACCEL_AVG_ROUND_EN (round half up instead of floor).
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   clear         flush buffer and sum; the average register keeps its value
//   wr_en         accept raw into buffer[wr_ptr] and update the sum
//   load_avg      capture the average of the updated sum
//   wr_ptr        shared write pointer from the controller
//   raw           signed input sample
//   avg           registered signed average
module accel_avg_channel
  import accel_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic                      load_avg,
  input  logic [N_LOG2-1:0]         wr_ptr,
  input  logic signed [ACCEL_W-1:0] raw,
  output logic signed [ACCEL_W-1:0] avg
);

  localparam int DEPTH = 1 << N_LOG2;
  localparam int SUM_W = sum_w(N_LOG2);

  logic signed [ACCEL_W-1:0] mem_q [DEPTH];
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [SUM_W-1:0]   sum_next;
  logic signed [SUM_W-1:0]   raw_ext;
  logic signed [SUM_W-1:0]   old_ext;
  logic signed [ACCEL_W-1:0] avg_next;

  assign raw_ext  = {{N_LOG2{raw[ACCEL_W-1]}}, raw};
  assign old_ext  = {{N_LOG2{mem_q[wr_ptr][ACCEL_W-1]}}, mem_q[wr_ptr]};
  assign sum_next = sum_q + raw_ext - old_ext;

`ifdef ACCEL_AVG_ROUND_EN
  // One guard bit so the half-LSB add cannot wrap at positive full scale.
  localparam logic signed [SUM_W:0] RND = (SUM_W+1)'(1 << (N_LOG2-1));
  logic signed [SUM_W:0] sum_wide;
  logic signed [SUM_W:0] sum_rnd;

  assign sum_wide = {sum_next[SUM_W-1], sum_next};
  assign sum_rnd  = sum_wide + RND;
  assign avg_next = ACCEL_W'(sum_rnd >>> N_LOG2);
`else
  assign avg_next = ACCEL_W'(sum_next >>> N_LOG2);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q <= '0;
      avg   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear) begin
      sum_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        sum_q         <= sum_next;
        mem_q[wr_ptr] <= raw;
      end
      if (load_avg) avg <= avg_next;
    end
  end

endmodule

// File: rtl/accel_averager.sv
// accel_averager -- three-axis moving-average filter over 2**N_LOG2 samples.
// Optional feature macro: ACCEL_AVG_ROUND_EN (round half up instead of floor).
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   clear                 flush all window contents (wins over sample_valid)
//   sample_valid          one-cycle strobe qualifying x/y/z_raw
//   x_raw, y_raw, z_raw   signed 16-bit samples
//   x_avg, y_avg, z_avg   signed registered averages
//   avg_valid             one-cycle strobe, averages updated this cycle
//   filled                window holds a full set of samples
//
// state | meaning
// FILL  | window not yet full since reset/clear; no averages produced
// RUN   | window full; every accepted sample produces an average
module accel_averager
  import accel_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      sample_valid,
  input  logic signed [ACCEL_W-1:0] x_raw,
  input  logic signed [ACCEL_W-1:0] y_raw,
  input  logic signed [ACCEL_W-1:0] z_raw,
  output logic signed [ACCEL_W-1:0] x_avg,
  output logic signed [ACCEL_W-1:0] y_avg,
  output logic signed [ACCEL_W-1:0] z_avg,
  output logic                      avg_valid,
  output logic                      filled
);

  state_t              state_q;
  state_t              state_d;
  logic [N_LOG2-1:0]   wr_ptr_q;
  logic [N_LOG2-1:0]   fill_cnt_q;
  logic                accept;
  logic                load_avg;

  assign accept = sample_valid & ~clear;
  assign filled = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    load_avg = 1'b0;
    case (state_q)
      FILL: begin
        // The sample that completes the window already yields an average.
        if (accept && fill_cnt_q == '1) begin
          state_d  = RUN;
          load_avg = 1'b1;
        end
      end
      RUN: begin
        if (clear) state_d = FILL;
        else       load_avg = accept;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      avg_valid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      avg_valid <= load_avg;
      if (clear) begin
        wr_ptr_q   <= '0;
        fill_cnt_q <= '0;
      end else if (accept) begin
        wr_ptr_q <= wr_ptr_q + N_LOG2'(1);
        if (state_q == FILL) fill_cnt_q <= fill_cnt_q + N_LOG2'(1);
      end
    end
  end

  accel_avg_channel #(.N_LOG2(N_LOG2)) u_x (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr_en(accept),
    .load_avg(load_avg), .wr_ptr(wr_ptr_q), .raw(x_raw), .avg(x_avg)
  );

  accel_avg_channel #(.N_LOG2(N_LOG2)) u_y (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr_en(accept),
    .load_avg(load_avg), .wr_ptr(wr_ptr_q), .raw(y_raw), .avg(y_avg)
  );

  accel_avg_channel #(.N_LOG2(N_LOG2)) u_z (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr_en(accept),
    .load_avg(load_avg), .wr_ptr(wr_ptr_q), .raw(z_raw), .avg(z_avg)
  );

endmodule

// File: tb/tb_accel_averager.sv
// tb_accel_averager -- directed bench for accel_averager with N_LOG2 = 3.
// Honours ACCEL_AVG_ROUND_EN for the expected rounding results.
module tb_accel_averager;

`ifdef ACCEL_AVG_ROUND_EN
  localparam int EXP_POS12 = 2;
  localparam int EXP_NEG12 = -1;
`else
  localparam int EXP_POS12 = 1;
  localparam int EXP_NEG12 = -2;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic               clear;
  logic               sample_valid;
  logic signed [15:0] x_raw, y_raw, z_raw;
  logic signed [15:0] x_avg, y_avg, z_avg;
  logic               avg_valid;
  logic               filled;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accel_averager #(.N_LOG2(3)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .sample_valid(sample_valid),
    .x_raw(x_raw), .y_raw(y_raw), .z_raw(z_raw),
    .x_avg(x_avg), .y_avg(y_avg), .z_avg(z_avg),
    .avg_valid(avg_valid), .filled(filled)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge; drives one strobe and checks the cycle after it.
  task automatic send(input int x, input int y, input int z, input bit exp_v,
                      input bit chk_avg, input int ex, input int ey, input int ez,
                      input string tag);
    sample_valid = 1'b1;
    x_raw = 16'(x);
    y_raw = 16'(y);
    z_raw = 16'(z);
    @(negedge clk);
    sample_valid = 1'b0;
    check({tag, " avg_valid"}, int'(avg_valid), int'(exp_v));
    if (chk_avg) begin
      check({tag, " x_avg"}, int'(x_avg), ex);
      check({tag, " y_avg"}, int'(y_avg), ey);
      check({tag, " z_avg"}, int'(z_avg), ez);
    end
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; sample_valid = 1'b0;
    x_raw = '0; y_raw = '0; z_raw = '0;
    repeat (2) @(negedge clk);
    check("reset x_avg", int'(x_avg), 0);
    check("reset y_avg", int'(y_avg), 0);
    check("reset z_avg", int'(z_avg), 0);
    check("reset avg_valid", int'(avg_valid), 0);
    check("reset filled", int'(filled), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Initial fill: nothing until the eighth strobe.
    for (int i = 0; i < 7; i++) send(1000, 2000, -500, 1'b0, 1'b0, 0, 0, 0, "fill");
    check("fill filled early", int'(filled), 0);
    send(1000, 2000, -500, 1'b1, 1'b1, 1000, 2000, -500, "fill8");
    check("fill8 filled", int'(filled), 1);
    @(negedge clk);
    check("idle avg_valid", int'(avg_valid), 0);
    check("idle x_avg hold", int'(x_avg), 1000);

    // Step and wrap, back-to-back strobes.
    send(1800, 2000, -500, 1'b1, 1'b1, 1100, 2000, -500, "step");
    for (int i = 0; i < 8; i++) send(1800, 2000, -500, 1'b1, 1'b0, 0, 0, 0, "wrap");
    check("wrap x_avg", int'(x_avg), 1800);

    // Clear together with a strobe: strobe dropped, averages hold.
    sample_valid = 1'b1; clear = 1'b1; x_raw = 16'(5000);
    @(negedge clk);
    sample_valid = 1'b0; clear = 1'b0;
    check("clr+sv avg_valid", int'(avg_valid), 0);
    check("clr+sv filled", int'(filled), 0);
    check("clr+sv x_avg hold", int'(x_avg), 1800);

    // Window {12,0,...} on x and {-12,0,...} on y.
    send(12, -12, 0, 1'b0, 1'b0, 0, 0, 0, "small");
    for (int i = 0; i < 6; i++) send(0, 0, 0, 1'b0, 1'b0, 0, 0, 0, "small");
    send(0, 0, 0, 1'b1, 1'b1, EXP_POS12, EXP_NEG12, 0, "small8");

    // Strobe in the cycle before clear still yields its average.
    sample_valid = 1'b1; x_raw = 16'(12); y_raw = -16'sd12; z_raw = '0;
    @(negedge clk);
    sample_valid = 1'b0; clear = 1'b1;
    check("pre-clr avg_valid", int'(avg_valid), 1);
    check("pre-clr x_avg", int'(x_avg), EXP_POS12);
    @(negedge clk);
    clear = 1'b0;
    check("post-clr avg_valid", int'(avg_valid), 0);
    check("post-clr filled", int'(filled), 0);

    // Full scale in both directions.
    for (int i = 0; i < 7; i++) send(32767, 32767, 32767, 1'b0, 1'b0, 0, 0, 0, "pos");
    send(32767, 32767, 32767, 1'b1, 1'b1, 32767, 32767, 32767, "pos8");
    for (int i = 0; i < 7; i++) send(-32768, -32768, -32768, 1'b1, 1'b0, 0, 0, 0, "neg");
    send(-32768, -32768, -32768, 1'b1, 1'b1, -32768, -32768, -32768, "neg8");

    // Reset mid-window.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 5; i++) send(800, 800, 800, 1'b0, 1'b0, 0, 0, 0, "pre-rst");
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst x_avg", int'(x_avg), 0);
    check("rst z_avg", int'(z_avg), 0);
    check("rst avg_valid", int'(avg_valid), 0);
    check("rst filled", int'(filled), 0);
    send(80, 160, -80, 1'b0, 1'b0, 0, 0, 0, "refill");
    for (int i = 0; i < 6; i++) send(0, 0, 0, 1'b0, 1'b0, 0, 0, 0, "refill");
    send(0, 0, 0, 1'b1, 1'b1, 10, 20, -10, "refill8");
    check("refill8 filled", int'(filled), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/accel_averager.md
ACCEL_AVERAGER -- requirements
Module: accel_averager

Interface
REQ-001 Parameter: N_LOG2, default 3, averaging window is 2**N_LOG2 samples.
REQ-002 clk  input  1  single system clock; all logic on posedge clk.
REQ-003 reset_n  input  1  reset is synchronous and active-low.
REQ-004 clear  input  1  synchronous flush of window contents, active-high.
REQ-005 sample_valid  input  1  one-cycle strobe; x_raw/y_raw/z_raw valid this cycle.
REQ-006 x_raw, y_raw, z_raw  input  16 each  signed two's-complement accelerometer samples.
REQ-007 x_avg, y_avg, z_avg  output  16 each  signed registered moving averages feeding the cue speed stage.
REQ-008 avg_valid  output  1  one-cycle strobe; x/y/z_avg updated this cycle.
REQ-009 filled  output  1  high once the window holds 2**N_LOG2 samples since reset/clear.

Function
REQ-010 Each axis SHALL keep a circular buffer of 2**N_LOG2 signed 16-bit entries, a shared write pointer of N_LOG2 bits and a signed running sum of 16+N_LOG2 bits.
REQ-011 On sample_valid: sum <= sum + raw - buffer[wr_ptr]; buffer[wr_ptr] <= raw; wr_ptr <= wr_ptr+1, wrapping from 2**N_LOG2-1 to 0 with no gap.
REQ-012 Running sum SHALL never overflow; full-scale inputs (all +32767 or all -32768) SHALL be representable.
REQ-013 Average SHALL be computed from the updated sum with an arithmetic right shift by N_LOG2 (floor toward minus infinity) and truncated to 16 bits.
REQ-014 Control FSM SHALL have two states: FILL (reset state) and RUN.
REQ-015 FILL: a fill counter increments on each sample_valid; on the sample that makes the count 2**N_LOG2, the FSM SHALL enter RUN and set filled.
REQ-016 RUN: the FSM SHALL remain in RUN until reset_n low or clear.
REQ-017 avg_valid SHALL pulse exactly one cycle after every sample_valid accepted in RUN, including the sample causing FILL->RUN; it SHALL never pulse in FILL.
REQ-018 x/y/z_avg SHALL update only in the avg_valid cycle and otherwise hold their values.
REQ-019 Back-to-back sample_valid on consecutive cycles SHALL be accepted, giving one avg_valid per sample.
REQ-020 clear SHALL zero buffers, sums, wr_ptr and fill counter, deassert filled, return to FILL, and leave x/y/z_avg holding their values.
REQ-021 When clear and sample_valid are both high in one cycle, clear SHALL win and the sample SHALL be dropped.
REQ-022 A sample accepted in the cycle before clear still produces its avg_valid pulse.

Reset
REQ-023 While reset_n is low at a clock edge: x/y/z_avg = 0, avg_valid = 0, filled = 0, state = FILL, and buffers, sums, wr_ptr and fill counter all 0.
REQ-024 reset_n low SHALL override clear and sample_valid, including mid-window.

Configuration
REQ-025 Macro ACCEL_AVG_ROUND_EN: when defined, average = (sum + 2**(N_LOG2-1)) >>> N_LOG2 (round half up).
REQ-026 Without ACCEL_AVG_ROUND_EN: floor shift per REQ-013; no rounding adder is instantiated.
REQ-027 With ACCEL_AVG_ROUND_EN, the rounding add SHALL not overflow at +32767 full scale; widen the sum by one bit internally if needed.

Structure
REQ-028 Shared package accel_pkg SHALL hold ACCEL_W=16, default N_LOG2, the sum-width expression and the FSM state enum (FILL, RUN).
REQ-029 One sub-module accel_avg_channel (buffer, running sum, shift/round) SHALL be instantiated three times; the FSM, fill counter and wr_ptr live in accel_averager.

Verification (N_LOG2=3)
REQ-030 Reset, then 8 strobes of x_raw=1000 -> no avg_valid for strobes 1-7; avg_valid one cycle after strobe 8 with x_avg=1000 and filled=1.
REQ-031 Continuing, one strobe of x_raw=1800 -> x_avg=1100 (sum 8800); 8 further strobes of 1800 -> x_avg=1800, confirming wrap.
REQ-032 Window holding one sample of 12 and seven of 0 -> x_avg=1 (floor), or 2 with ACCEL_AVG_ROUND_EN; same window with -12 -> -2 (floor), or -1 (round).
REQ-033 8 strobes of all axes at +32767, then 8 at -32768 -> averages exactly 32767, then -32768; no wrap in either mode.
REQ-034 clear asserted with sample_valid in RUN -> no avg_valid, filled=0, averages hold; next 7 strobes give no avg_valid, and the 8th does.
REQ-035 reset_n low for one cycle mid-window after 5 strobes -> all outputs 0, FILL; 8 fresh strobes needed before avg_valid.
